// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-style memory port between instruction
// fetch and the MEM-stage load/store path. One transaction at a time,
// registered read data, one-cycle ready pulse back to the owner.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add an ack timeout that
// completes a stuck transaction with rdata=0 and a mem_err pulse.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ready,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ready,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [DW/8-1:0] mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA, S_RESP} state_t;

  state_t state_reg, state_next;
  logic   owner_data_reg;      // owner of the current transaction: 1 = data
  logic   last_data_reg;       // owner of the previous transaction: 1 = data
  logic   grant_inst, grant_data;
  logic   busy;
  logic   timeout_hit;

  assign busy = (state_reg == S_INST) || (state_reg == S_DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        tmo_flag_reg;

  assign timeout_hit = busy && !mem_ack && (tmo_cnt_reg == 16'(TIMEOUT - 1));

  // Ack-wait counter: cleared on grant, advances on every bus cycle without ack
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_reg  <= '0;
      tmo_flag_reg <= 1'b0;
    end else begin
      if (grant_inst || grant_data) begin
        tmo_cnt_reg  <= '0;
        tmo_flag_reg <= 1'b0;
      end else if (busy && !mem_ack) begin
        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
      if (timeout_hit) begin
        tmo_flag_reg <= 1'b1;
      end else if (state_reg == S_RESP) begin
        tmo_flag_reg <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset aborts any transaction without a ready pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, arbitration and status outputs
  always_comb begin
    state_next = state_reg;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // data wins a tie unless it owned the previous transaction
        if (data_req && (!inst_req || !last_data_reg)) begin
          grant_data = 1'b1;
          state_next = S_DATA;
        end else if (inst_req && (!data_req || last_data_reg)) begin
          grant_inst = 1'b1;
          state_next = S_INST;
        end
      end
      S_INST, S_DATA: begin
        if (mem_ack || timeout_hit) begin
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    mem_req    = busy;
    inst_ready = (state_reg == S_RESP) && !owner_data_reg;
    data_ready = (state_reg == S_RESP) && owner_data_reg;
`ifdef MEM_ARB_TIMEOUT_EN
    mem_err    = (state_reg == S_RESP) && tmo_flag_reg;
`else
    mem_err    = 1'b0;
`endif
  end

  // Bus request latching, read-data capture and ownership history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr       <= '0;
      mem_wr         <= 1'b0;
      mem_wen        <= '0;
      mem_wdata      <= '0;
      inst_rdata     <= '0;
      data_rdata     <= '0;
      owner_data_reg <= 1'b0;
      last_data_reg  <= 1'b0;
    end else begin
      if (grant_data) begin
        mem_addr       <= data_addr;
        mem_wr         <= data_wr;
        mem_wen        <= data_wr ? data_wen : '0;
        mem_wdata      <= data_wdata;
        owner_data_reg <= 1'b1;
      end else if (grant_inst) begin
        mem_addr       <= inst_addr;
        mem_wr         <= 1'b0;
        mem_wen        <= '0;
        mem_wdata      <= '0;
        owner_data_reg <= 1'b0;
      end
      if (busy && mem_ack) begin
        if (!owner_data_reg) begin
          inst_rdata <= mem_rdata;
        end else if (!mem_wr) begin
          data_rdata <= mem_rdata;   // stores leave load data untouched
        end
      end else if (timeout_hit) begin
        if (!owner_data_reg) begin
          inst_rdata <= '0;
        end else begin
          data_rdata <= '0;
        end
      end
      if (state_reg == S_RESP) begin
        last_data_reg <= owner_data_reg;
      end
    end
  end

endmodule
